// File: rtl/fnd_scan_driver.sv
// 4-digit multiplexed 7-segment driver: saturating binary-to-BCD double-dabble plus a free-running digit scan.
// Optional leading-zero blanking is enabled by defining FND_LZB_EN.
module fnd_scan_driver #(
    parameter int SCAN_DIV = 100000,
    parameter int MAX_VAL  = 9999
) (
    input  logic        sysclk,
    input  logic        i_rst_n,
    input  logic [13:0] i_value,
    output logic [15:0] o_bcd,
    output logic [7:0]  o_seg,
    output logic [3:0]  o_digit
);

    typedef enum logic [1:0] {IDLE, CONV, LATCH} state_t;

    localparam logic [13:0] MAX_V    = 14'(MAX_VAL);
    localparam int          CW       = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

    state_t        state_reg, state_next;
    logic [13:0]   shreg_reg, shreg_next;
    logic [15:0]   scratch_reg, scratch_next;
    logic [3:0]    iter_reg, iter_next;
    logic [15:0]   bcd_next;
    logic [15:0]   adj;

    logic [CW-1:0] cnt_reg;
    logic [1:0]    idx_reg, idx_next;
    logic          wrap;
    logic [7:0]    slot_seg [4];

    function automatic logic [7:0] decode(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'd0:    seg = 8'hC0;
            4'd1:    seg = 8'hF9;
            4'd2:    seg = 8'hA4;
            4'd3:    seg = 8'hB0;
            4'd4:    seg = 8'h99;
            4'd5:    seg = 8'h92;
            4'd6:    seg = 8'h82;
            4'd7:    seg = 8'hF8;
            4'd8:    seg = 8'h80;
            4'd9:    seg = 8'h90;
            default: seg = 8'hFF;
        endcase
        return seg;
    endfunction

    // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_adj
            assign adj[4*gi +: 4] = (scratch_reg[4*gi +: 4] >= 4'd5) ?
                                    scratch_reg[4*gi +: 4] + 4'd3 : scratch_reg[4*gi +: 4];
        end
    endgenerate

    always_ff @(posedge sysclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg   <= IDLE;
            shreg_reg   <= '0;
            scratch_reg <= '0;
            iter_reg    <= '0;
            o_bcd       <= '0;
        end else begin
            state_reg   <= state_next;
            shreg_reg   <= shreg_next;
            scratch_reg <= scratch_next;
            iter_reg    <= iter_next;
            o_bcd       <= bcd_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        shreg_next   = shreg_reg;
        scratch_next = scratch_reg;
        iter_next    = iter_reg;
        bcd_next     = o_bcd;
        case (state_reg)
            IDLE: begin
                shreg_next   = (i_value > MAX_V) ? MAX_V : i_value;
                scratch_next = '0;
                iter_next    = '0;
                state_next   = CONV;
            end
            CONV: begin
                {scratch_next, shreg_next} = {adj, shreg_reg} << 1;
                iter_next = iter_reg + 4'd1;
                if (iter_reg == 4'd13)
                    state_next = LATCH;
            end
            LATCH: begin
                bcd_next   = scratch_reg;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Per-slot segment pattern, computed from the stable latched result.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_slot
`ifdef FND_LZB_EN
            if (gi > 0) begin : g_blank
                assign slot_seg[gi] = (o_bcd[15:4*gi] == '0) ? 8'hFF : decode(o_bcd[4*gi +: 4]);
            end else begin : g_keep
                assign slot_seg[gi] = decode(o_bcd[4*gi +: 4]);
            end
`else
            assign slot_seg[gi] = decode(o_bcd[4*gi +: 4]);
`endif
        end
    endgenerate

    assign wrap     = (cnt_reg == CNT_LAST);
    assign idx_next = idx_reg + 2'd1;

    always_ff @(posedge sysclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_reg <= '0;
            idx_reg <= '0;
            o_digit <= 4'hF;
            o_seg   <= 8'hFF;
        end else if (wrap) begin
            cnt_reg <= '0;
            idx_reg <= idx_next;
            o_digit <= ~(4'b0001 << idx_next);
            o_seg   <= slot_seg[idx_next];
        end else begin
            cnt_reg <= cnt_reg + CW'(1);
        end
    end

endmodule

// File: tb/tb_fnd_scan_driver.sv
// Self-checking bench for fnd_scan_driver with a fast scan (SCAN_DIV=4) and a BCD scoreboard.
module tb_fnd_scan_driver;

    logic        sysclk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [13:0] i_value = '0;
    logic [15:0] o_bcd;
    logic [7:0]  o_seg;
    logic [3:0]  o_digit;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [15:0] exp_q [$];

    fnd_scan_driver #(.SCAN_DIV(4), .MAX_VAL(9999)) dut (
        .sysclk (sysclk),
        .i_rst_n(i_rst_n),
        .i_value(i_value),
        .o_bcd  (o_bcd),
        .o_seg  (o_seg),
        .o_digit(o_digit)
    );

    always #5 sysclk = ~sysclk;

    function automatic logic [7:0] dec7(input logic [3:0] n);
        logic [7:0] t [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
        if (n > 4'd9) return 8'hFF;
        return t[n];
    endfunction

    function automatic logic [15:0] ref_bcd(input int v);
        int s;
        s = (v > 9999) ? 9999 : v;
        return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    function automatic logic [7:0] exp_seg(input logic [15:0] b, input int idx);
        logic [15:0] hi;
        hi = b >> (4 * idx);
`ifdef FND_LZB_EN
        if (idx > 0 && hi == 16'h0) return 8'hFF;
`endif
        return dec7(hi[3:0]);
    endfunction

    task automatic tick();
        @(posedge sysclk);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input int v);
        i_value = 14'(v);
        i_rst_n = 1'b0;
        repeat (2) @(posedge sysclk);
        @(negedge sysclk);
        i_rst_n = 1'b1;
        cyc = 0;
    endtask

    task automatic check_bcd(input string name);
        logic [15:0] exp;
        exp = exp_q.pop_front();
        checks++;
        if (o_bcd !== exp) begin
            errors++;
            $display("FAIL %s: o_bcd=%h expected %h (cyc %0d)", name, o_bcd, exp, cyc);
        end else begin
            $display("bcd %s: o_bcd=%h ok (cyc %0d)", name, o_bcd, cyc);
        end
    endtask

    // Checks the digit/segment pair every cycle for n cycles, assuming b was latched before the last wrap.
    task automatic check_scan(input string name, input logic [15:0] b, input int n);
        int idx;
        logic [3:0] ed;
        logic [7:0] es;
        for (int k = 0; k < n; k++) begin
            tick();
            idx = (cyc / 4) % 4;
            if (cyc < 4) begin
                ed = 4'hF;
                es = 8'hFF;
            end else begin
                ed = ~(4'b0001 << idx);
                es = exp_seg(b, idx);
            end
            checks++;
            if (o_digit !== ed || o_seg !== es) begin
                errors++;
                $display("FAIL %s cyc %0d: o_digit=%h o_seg=%h expected %h %h", name, cyc, o_digit, o_seg, ed, es);
            end
        end
        $display("scan %s: %0d cycles checked for %h", name, n, b);
    endtask

    task automatic test_reset();
        do_reset(0);
        i_rst_n = 1'b0;
        #1;
        checks++;
        if (o_bcd !== 16'h0 || o_seg !== 8'hFF || o_digit !== 4'hF) begin
            errors++;
            $display("FAIL reset_state: bcd=%h seg=%h digit=%h expected 0000 ff f", o_bcd, o_seg, o_digit);
        end
        @(negedge sysclk);
        i_rst_n = 1'b1;
        cyc = 0;
        exp_q.push_back(ref_bcd(0));
        check_scan("reset_scan", 16'h0, 16);
        check_bcd("reset_zero");
    endtask

    task automatic test_1234();
        do_reset(1234);
        exp_q.push_back(ref_bcd(1234));
        repeat (16) tick();
        check_bcd("conv_1234");
        repeat (3) tick();
        check_scan("scan_1234", 16'h1234, 32);
    endtask

    task automatic test_saturation();
        int vals [2] = '{12000, 16383};
        foreach (vals[i]) begin
            i_value = 14'(vals[i]);
            exp_q.push_back(ref_bcd(vals[i]));
            repeat (36) tick();
            check_bcd($sformatf("sat_%0d", vals[i]));
            check_scan($sformatf("sat_scan_%0d", vals[i]), ref_bcd(vals[i]), 16);
        end
    endtask

    task automatic test_back_to_back();
        do_reset(5);
        tick();
        i_value = 14'd9876;
        exp_q.push_back(ref_bcd(5));
        repeat (15) tick();
        check_bcd("b2b_first");
        exp_q.push_back(ref_bcd(5));
        repeat (15) tick();
        check_bcd("b2b_hold");
        exp_q.push_back(ref_bcd(9876));
        tick();
        check_bcd("b2b_second");
    endtask

    task automatic test_reset_mid_conv();
        int guard;
        i_value = 14'd5555;
        exp_q.push_back(ref_bcd(5555));
        repeat (40) tick();
        check_bcd("pre_abort");
        guard = 0;
        while (cyc % 16 != 8 && guard < 32) begin
            tick();
            guard++;
        end
        checks++;
        if (cyc % 16 != 8) begin
            errors++;
            $display("FAIL align_conv: cyc=%0d required phase 8", cyc);
        end
        #2;
        i_rst_n = 1'b0;
        #1;
        checks++;
        if (o_bcd !== 16'h0 || o_seg !== 8'hFF || o_digit !== 4'hF) begin
            errors++;
            $display("FAIL async_abort: bcd=%h seg=%h digit=%h expected 0000 ff f", o_bcd, o_seg, o_digit);
        end
        i_value = 14'd777;
        repeat (2) @(posedge sysclk);
        @(negedge sysclk);
        i_rst_n = 1'b1;
        cyc = 0;
        exp_q.push_back(ref_bcd(777));
        check_scan("post_abort_scan", 16'h0, 15);
        tick();
        check_bcd("post_abort");
    endtask

    task automatic test_lzb();
        int vals [2] = '{42, 0};
        foreach (vals[i]) begin
            i_value = 14'(vals[i]);
            exp_q.push_back(ref_bcd(vals[i]));
            repeat (36) tick();
            check_bcd($sformatf("lzb_%0d", vals[i]));
            check_scan($sformatf("lzb_scan_%0d", vals[i]), ref_bcd(vals[i]), 16);
        end
    endtask

    initial begin
        test_reset();
        test_1234();
        test_saturation();
        test_back_to_back();
        test_reset_mid_conv();
        test_lzb();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
